pointer_mem_access: RTL

//  Load/store unit consuming a pointer (label id + offset) read from the pointer register file.

---
 rtl/pointer_mem_access_pkg.sv | 18 +
 rtl/pointer_mem_access_label_table.sv | 72 +++++++
 rtl/pointer_mem_access.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pointer_mem_access_pkg.sv
// Shared definitions for the pointer load/store unit.
//   LBID_W  : pointer label id width (shared with the pointer register file)
//   OFS_W   : pointer offset width in words
//   state_e : access FSM encoding
package pointer_mem_access_pkg;

    localparam int unsigned LBID_W = 12;
    localparam int unsigned OFS_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/pointer_mem_access_label_table.sv
// Label table: 2**LBL_AW entries of (base, size) plus a valid bit per entry.
//   clk_i, reset_i          : clock, synchronous active-high reset (clears valid bits only)
//   wr_en_i, wr_idx_i       : entry write strobe and index
//   wr_base_i, wr_size_i    : entry contents; a write also sets the valid bit
//   rd_en_i, rd_idx_i       : registered read strobe and index
//   rd_base_o/size_o/valid_o: read result, available the cycle after rd_en_i
module pointer_mem_access_label_table #(
    parameter int unsigned LBL_AW = 6,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [LBL_AW-1:0] wr_idx_i,
    input  logic [ADDR_W-1:0] wr_base_i,
    input  logic [ADDR_W-1:0] wr_size_i,
    input  logic              rd_en_i,
    input  logic [LBL_AW-1:0] rd_idx_i,
    output logic [ADDR_W-1:0] rd_base_o,
    output logic [ADDR_W-1:0] rd_size_o,
    output logic              rd_valid_o
);

    localparam int unsigned Depth = 2 ** LBL_AW;

    logic [ADDR_W-1:0] base_mem [Depth];
    logic [ADDR_W-1:0] size_mem [Depth];
    logic [Depth-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] rd_base_q, rd_size_q;
    logic              rd_valid_q;

    // Storage is deliberately not reset; only the valid bits are.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            base_mem[wr_idx_i] <= wr_base_i;
            size_mem[wr_idx_i] <= wr_size_i;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Read samples pre-write contents when it collides with a write to the same index.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_base_q  <= '0;
            rd_size_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (rd_en_i) begin
            rd_base_q  <= base_mem[rd_idx_i];
            rd_size_q  <= size_mem[rd_idx_i];
            rd_valid_q <= valid_q[rd_idx_i];
        end
    end

    assign rd_base_o  = rd_base_q;
    assign rd_size_o  = rd_size_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/pointer_mem_access.sv
// Pointer load/store unit: resolves (label id, offset) through the label table into a
// data-memory word address and performs one synchronous-RAM access per request.
// Fixed 4-cycle accept-to-response latency, one request in flight.
// Optional feature: define BOUNDS_CHECK_EN to reject out-of-range / invalid-label accesses.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   req_valid/ready/write         : request handshake and direction (1 = store)
//   req_lbid, req_ofs, req_wdata  : pointer label id, word offset, store data
//   lbl_we, lbl_id, lbl_base/size : label table write port
//   mem_en/we/addr/wdata, mem_rdata : data-memory port (rdata one cycle after mem_en)
//   rsp_valid/rdata/fault         : one-cycle response to the execute stage
module pointer_mem_access
    import pointer_mem_access_pkg::*;
#(
    parameter int unsigned LBL_AW = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [LBID_W-1:0] req_lbid,
    input  logic [ADDR_W-1:0] req_ofs,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              lbl_we,
    input  logic [LBID_W-1:0] lbl_id,
    input  logic [ADDR_W-1:0] lbl_base,
    input  logic [ADDR_W-1:0] lbl_size,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault
);

    state_e                   state_q, state_d;
    logic                     write_q, write_d;
    logic [LBID_W-LBL_AW-1:0] lbid_hi_q, lbid_hi_d;
    logic [ADDR_W-1:0]        ofs_q, ofs_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic                     fault_q, fault_d;
    logic                     req_ready_q, req_ready_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_fault_q, rsp_fault_d;

    logic                     tbl_wr_en;
    logic                     tbl_rd_en;
    logic [ADDR_W-1:0]        tbl_rd_base, tbl_rd_size;
    logic                     tbl_rd_valid;
    logic [ADDR_W-1:0]        phys_addr;
    logic                     access_fault;

    // Ids beyond the table range never touch it.
    assign tbl_wr_en = lbl_we && (lbl_id[LBID_W-1:LBL_AW] == '0);

    // Table is read on the accept edge so its contents are ready during LOOKUP.
    pointer_mem_access_label_table #(
        .LBL_AW (LBL_AW),
        .ADDR_W (ADDR_W)
    ) u_label_table (
        .clk_i      (clk),
        .reset_i    (reset),
        .wr_en_i    (tbl_wr_en),
        .wr_idx_i   (lbl_id[LBL_AW-1:0]),
        .wr_base_i  (lbl_base),
        .wr_size_i  (lbl_size),
        .rd_en_i    (tbl_rd_en),
        .rd_idx_i   (req_lbid[LBL_AW-1:0]),
        .rd_base_o  (tbl_rd_base),
        .rd_size_o  (tbl_rd_size),
        .rd_valid_o (tbl_rd_valid)
    );

    // Address wraps modulo 2**ADDR_W.
    assign phys_addr = tbl_rd_base + ofs_q;

`ifdef BOUNDS_CHECK_EN
    assign access_fault = (lbid_hi_q != '0) || !tbl_rd_valid || (ofs_q >= tbl_rd_size);
`else
    logic unused_chk;
    assign access_fault = 1'b0;
    assign unused_chk   = ^{lbid_hi_q, tbl_rd_valid, tbl_rd_size};
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        lbid_hi_d   = lbid_hi_q;
        ofs_d       = ofs_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
        tbl_rd_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    write_d   = req_write;
                    lbid_hi_d = req_lbid[LBID_W-1:LBL_AW];
                    ofs_d     = req_ofs;
                    wdata_d   = req_wdata;
                    tbl_rd_en = 1'b1;
                    state_d   = StLookup;
                end
            end
            StLookup: begin
                // Decide the access here so mem_* is a clean register output in ISSUE.
                fault_d     = access_fault;
                mem_en_d    = !access_fault;
                mem_we_d    = write_q && !access_fault;
                mem_addr_d  = phys_addr;
                mem_wdata_d = wdata_q;
                state_d     = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // mem_rdata is valid this cycle; it lands directly in the response register.
                rsp_valid_d = 1'b1;
                rsp_fault_d = fault_q;
                rsp_rdata_d = (write_q || fault_q) ? '0 : mem_rdata;
                state_d     = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            lbid_hi_q   <= '0;
            ofs_q       <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            req_ready_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            lbid_hi_q   <= lbid_hi_d;
            ofs_q       <= ofs_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            req_ready_q <= req_ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule
